// File: rtl/tc_pkg.sv
// Shared types and helpers for the tensor-core result path: array geometry,
// drain FSM states and the signed saturating narrow used on PE accumulators.
package tc_pkg;
    localparam int ARRAY_DIM  = 4;
    localparam int WARP_LANES = 8;
    localparam int NUM_PE     = ARRAY_DIM * ARRAY_DIM;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} drain_state_e;

    // Clamp a sign-extended value into the signed range of dw bits.
    function automatic logic signed [63:0] sat_narrow_f(input logic signed [63:0] v,
                                                        input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction
endpackage

// File: rtl/result_drain_unit_sat_narrow.sv
// Combinational signed narrowing of one accumulator with saturation;
// ovf flags that the value had to be clamped.
module sat_narrow
    import tc_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  ovf
);
    generate
        if (ACC_WIDTH == DATA_WIDTH) begin : g_pass
            assign value = acc;
            assign ovf   = 1'b0;
        end else begin : g_sat
            logic signed [63:0] wide;
            logic signed [63:0] narrowed;
            always_comb begin
                wide     = 64'(signed'(acc));
                narrowed = sat_narrow_f(wide, DATA_WIDTH);
                value    = narrowed[DATA_WIDTH-1:0];
                ovf      = (narrowed != wide);
            end
        end
    endgenerate
endmodule

// File: rtl/result_drain_unit.sv
// Snapshots the 4x4 array accumulators on a matmul_done rise, saturates them
// and returns them to the warp register file as two 8-lane valid/ready beats.
module result_drain_unit
    import tc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  pause,
    input  logic                                  matmul_done,
    input  logic [NUM_PE-1:0][ACC_WIDTH-1:0]      acc_in,
    input  logic                                  wb_ready,
    output logic                                  wb_valid,
    output logic                                  wb_beat,
    output logic [WARP_LANES-1:0][DATA_WIDTH-1:0] wb_data,
    output logic                                  pe_clear,
    output logic                                  busy,
    output logic                                  drain_done,
    output logic                                  sat_flag,
    output logic                                  overrun
);
    drain_state_e state, state_nxt;
    logic done_q, pending, first_q;
    logic rise, capture;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] narrowed;
    logic [NUM_PE-1:0]                 ovf;
    logic [NUM_PE-1:0][DATA_WIDTH-1:0] res_q;

    generate
        for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
            sat_narrow #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sat (
                .acc   (acc_in[k]),
                .value (narrowed[k]),
                .ovf   (ovf[k])
            );
        end
    endgenerate

    assign rise    = matmul_done & ~done_q;
    // A rise that arrives while paused is remembered in pending; acc_in is
    // taken at the capture edge because the array holds its result meanwhile.
    assign capture = (state == IDLE) & (rise | pending) & ~pause;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            pending  <= 1'b0;
            first_q  <= 1'b0;
            sat_flag <= 1'b0;
            overrun  <= 1'b0;
            res_q    <= '0;
        end else begin
            state   <= state_nxt;
            done_q  <= matmul_done;
            first_q <= capture;
            if (state == IDLE)
                pending <= (pending | rise) & ~capture;
            if (rise && state != IDLE)
                overrun <= 1'b1;
            if (capture) begin
                res_q    <= narrowed;
                sat_flag <= |ovf;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        wb_valid   = 1'b0;
        wb_beat    = 1'b0;
        busy       = (state != IDLE);
        drain_done = 1'b0;
        pe_clear   = first_q;
        case (state)
            IDLE:  if (capture) state_nxt = BEAT0;
            BEAT0: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nxt = BEAT1;
            end
            BEAT1: begin
                wb_valid = 1'b1;
                wb_beat  = 1'b1;
                if (wb_ready) state_nxt = DONE;
            end
            DONE: begin
                drain_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane i of beat b is accumulator 8*b + i; data is zero outside a beat.
    always_comb begin
        for (int i = 0; i < WARP_LANES; i++) begin
            if (state == BEAT0)      wb_data[i] = res_q[i];
            else if (state == BEAT1) wb_data[i] = res_q[WARP_LANES + i];
            else                     wb_data[i] = '0;
        end
    end
endmodule

// File: tb/tb_result_drain_unit.sv
// Directed bench for result_drain_unit: capture latency, saturation,
// backpressure, pause, level retrigger/overrun and asynchronous reset.
module tb_result_drain_unit;
    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 pause;
    logic                 matmul_done;
    logic [15:0][31:0]    acc_in;
    logic                 wb_ready;
    logic                 wb_valid;
    logic                 wb_beat;
    logic [7:0][15:0]     wb_data;
    logic                 pe_clear;
    logic                 busy;
    logic                 drain_done;
    logic                 sat_flag;
    logic                 overrun;

    int checks = 0;
    int errors = 0;
    int n_clear, n_done;
    logic [7:0][15:0] exp_data;

    result_drain_unit #(.DATA_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .pause(pause), .matmul_done(matmul_done),
        .acc_in(acc_in), .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_beat(wb_beat),
        .wb_data(wb_data), .pe_clear(pe_clear), .busy(busy), .drain_done(drain_done),
        .sat_flag(sat_flag), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input int base);
        for (int k = 0; k < 16; k++) acc_in[k] = 32'(base + k);
    endtask

    function automatic logic [127:0] lanes(input int base);
        logic [7:0][15:0] v;
        for (int i = 0; i < 8; i++) v[i] = 16'(base + i);
        return v;
    endfunction

    initial begin
        reset_n = 1'b0; pause = 1'b0; matmul_done = 1'b0; wb_ready = 1'b0;
        acc_in = '0;
        #12;
        check("rst_valid", wb_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", wb_data, '0);
        check("rst_clear", pe_clear, 1'b0);
        check("rst_done", drain_done, 1'b0);
        check("rst_sat", sat_flag, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        reset_n = 1'b1;
        tick(); tick();

        // 1: basic drain, wb_ready held high
        set_acc(1); wb_ready = 1'b1; matmul_done = 1'b1;
        tick();
        check("t1_clear", pe_clear, 1'b1);
        check("t1_valid0", wb_valid, 1'b1);
        check("t1_beat0", wb_beat, 1'b0);
        check("t1_data0", wb_data, lanes(1));
        tick();
        check("t1_clear_off", pe_clear, 1'b0);
        check("t1_beat1", wb_beat, 1'b1);
        check("t1_data1", wb_data, lanes(9));
        tick();
        check("t1_done", drain_done, 1'b1);
        check("t1_valid_done", wb_valid, 1'b0);
        check("t1_busy_done", busy, 1'b1);
        check("t1_data_done", wb_data, '0);
        check("t1_sat", sat_flag, 1'b0);
        tick();
        check("t1_idle", busy, 1'b0);
        check("t1_done_off", drain_done, 1'b0);
        matmul_done = 1'b0;
        tick();

        // 2: saturation both ways
        acc_in = '0; acc_in[0] = 32'd70000; acc_in[5] = -32'sd40000;
        matmul_done = 1'b1;
        tick();
        exp_data = '0; exp_data[0] = 16'h7FFF; exp_data[5] = 16'h8000;
        check("t2_data0", wb_data, exp_data);
        check("t2_sat", sat_flag, 1'b1);
        matmul_done = 1'b0;
        tick(); tick(); tick();
        check("t2_idle", busy, 1'b0);
        check("t2_sat_hold", sat_flag, 1'b1);

        // 3: backpressure in BEAT0 with acc_in changing underneath
        set_acc(100); wb_ready = 1'b0; matmul_done = 1'b1;
        tick();
        check("t3_clear", pe_clear, 1'b1);
        matmul_done = 1'b0;
        for (int k = 0; k < 16; k++) acc_in[k] = 32'h12345;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t3_hold_valid", wb_valid, 1'b1);
            check("t3_hold_beat", wb_beat, 1'b0);
            check("t3_hold_data", wb_data, lanes(100));
            check("t3_hold_clear", pe_clear, 1'b0);
        end
        wb_ready = 1'b1;
        tick();
        check("t3_beat1", wb_beat, 1'b1);
        check("t3_data1", wb_data, lanes(108));
        check("t3_sat_clr", sat_flag, 1'b0);
        tick();
        check("t3_done", drain_done, 1'b1);
        tick();

        // 4: rise while paused; pause during beats must not drop wb_valid
        set_acc(200); pause = 1'b1; matmul_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_paused_valid", wb_valid, 1'b0);
            check("t4_paused_clear", pe_clear, 1'b0);
            check("t4_paused_busy", busy, 1'b0);
        end
        set_acc(300); pause = 1'b0;
        tick();
        check("t4_clear", pe_clear, 1'b1);
        check("t4_data0", wb_data, lanes(300));
        pause = 1'b1; wb_ready = 1'b0;
        tick();
        check("t4_pause_valid", wb_valid, 1'b1);
        wb_ready = 1'b1;
        tick();
        check("t4_beat1_valid", wb_valid, 1'b1);
        check("t4_data1", wb_data, lanes(308));
        tick();
        check("t4_done", drain_done, 1'b1);
        pause = 1'b0; matmul_done = 1'b0;
        tick(); tick();

        // 5: level held high gives one drain; a rise in BEAT1 is an overrun
        set_acc(400); matmul_done = 1'b1;
        n_clear = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_clear += int'(pe_clear);
            n_done  += int'(drain_done);
        end
        check("t5_one_clear", 32'(n_clear), 32'd1);
        check("t5_one_done", 32'(n_done), 32'd1);
        check("t5_no_ovr", overrun, 1'b0);
        matmul_done = 1'b0;
        tick();
        matmul_done = 1'b1;
        tick();
        check("t5_beat0", wb_valid, 1'b1);
        matmul_done = 1'b0;
        tick();
        check("t5_beat1", wb_beat, 1'b1);
        matmul_done = 1'b1;
        tick();
        check("t5_ovr", overrun, 1'b1);
        check("t5_done", drain_done, 1'b1);
        n_clear = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_clear += int'(pe_clear);
        end
        check("t5_no_redrain", 32'(n_clear), 32'd0);
        check("t5_idle", busy, 1'b0);
        check("t5_ovr_sticky", overrun, 1'b1);

        // 6: async reset in BEAT1
        matmul_done = 1'b0;
        tick();
        set_acc(500); matmul_done = 1'b1;
        tick(); tick();
        check("t6_in_beat1", wb_beat, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", wb_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ovr", overrun, 1'b0);
        check("t6_rst_data", wb_data, '0);
        matmul_done = 1'b0;
        tick();
        check("t6_rst_nodone", drain_done, 1'b0);
        reset_n = 1'b1;
        tick();
        matmul_done = 1'b1;
        tick();
        check("t6_clear", pe_clear, 1'b1);
        check("t6_data0", wb_data, lanes(500));
        tick();
        check("t6_data1", wb_data, lanes(508));
        tick();
        check("t6_done", drain_done, 1'b1);
        tick();
        check("t6_idle", busy, 1'b0);
        check("t6_ovr", overrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
